// File: rtl/memory_stage_if.sv
// Data-memory port of the memory stage: word request/ready handshake.
// The stage is the master; the memory (or its arbiter) is the slave.
interface memory_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/memory_stage.sv
// Memory-access stage: plain/stack loads and stores through a ready handshake,
// two-word PC push/pop sequencing with upstream stall, MEM/WB result registers.
//
// state  | meaning
// IDLE   | pass-through of EX/MEM bundle, or launch of a memory access
// ACC_LO | first (or only) word in flight, waiting for ready
// ACC_HI | second word of a PC push/pop in flight
// DONE   | results presented for one cycle, EX/MEM advances at the edge
module memory_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Data,
  input  logic [31:0]           Address,
  input  logic [2:0]            WB_Address,
  input  logic                  MR,
  input  logic                  MW,
  input  logic                  WB,
  input  logic                  Stack_PC,
  input  logic                  Stack_Flags,
  input  logic [2:0]            Final_Flags,
  memory_stage_if.master        mem,
  output logic                  Stall,
  output logic                  WB_Out,
  output logic [2:0]            WB_Address_Out,
  output logic [DATA_WIDTH-1:0] WB_Data,
  output logic [31:0]           PC_Out,
  output logic                  PC_Valid,
  output logic [2:0]            Flags_Out,
  output logic                  Flags_Valid
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state;
  logic                  op_write;
  logic                  op_pc;
  logic                  op_flags;
  logic                  op_wb;
  logic [2:0]            op_wb_addr;
  logic [DATA_WIDTH-1:0] op_data_lo;
  logic [DATA_WIDTH-1:0] lo_word;
  logic                  busy;
  logic                  finish;
  logic [DATA_WIDTH-1:0] first_wdata;

  assign busy    = (state == ACC_LO) || (state == ACC_HI);
  assign mem.req = busy;

  // Last word of the access completes this cycle.
  assign finish = busy && mem.ready && ((state == ACC_HI) || !op_pc);

  // Gated by reset so an access abandoned mid-flight releases the pipeline at once.
  assign Stall = reset && (busy || ((state == IDLE) && (MR || MW)));

  always_comb begin
    first_wdata = Data[DATA_WIDTH-1:0];
    if (Stack_PC)
      first_wdata = Data[2*DATA_WIDTH-1:DATA_WIDTH];
    else if (Stack_Flags)
      first_wdata = {{(DATA_WIDTH-3){1'b0}}, Final_Flags};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op_write       <= 1'b0;
      op_pc          <= 1'b0;
      op_flags       <= 1'b0;
      op_wb          <= 1'b0;
      op_wb_addr     <= '0;
      op_data_lo     <= '0;
      lo_word        <= '0;
      mem.we         <= 1'b0;
      mem.addr       <= '0;
      mem.wdata      <= '0;
      WB_Out         <= 1'b0;
      WB_Address_Out <= '0;
      WB_Data        <= '0;
      PC_Out         <= '0;
      PC_Valid       <= 1'b0;
      Flags_Out      <= '0;
      Flags_Valid    <= 1'b0;
    end else begin
      PC_Valid    <= 1'b0;
      Flags_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (MR || MW) begin
            state      <= ACC_LO;
            op_write   <= MW;
            op_pc      <= Stack_PC;
            op_flags   <= Stack_Flags && !Stack_PC;
            op_wb      <= WB;
            op_wb_addr <= WB_Address;
            op_data_lo <= Data[DATA_WIDTH-1:0];
            mem.we     <= MW;
            mem.addr   <= Address[ADDR_WIDTH-1:0];
            mem.wdata  <= MW ? first_wdata : '0;
            WB_Out     <= 1'b0;
          end else begin
            WB_Out         <= WB;
            WB_Address_Out <= WB_Address;
            WB_Data        <= Data[DATA_WIDTH-1:0];
          end
        end
        ACC_LO: begin
          if (mem.ready) begin
            if (op_pc) begin
              // Push descends the stack, pop ascends; both wrap modulo 2^ADDR_WIDTH.
              state     <= ACC_HI;
              lo_word   <= mem.rdata;
              mem.addr  <= op_write ? mem.addr - ADDR_ONE : mem.addr + ADDR_ONE;
              mem.wdata <= op_data_lo;
            end else begin
              state <= DONE;
            end
          end
        end
        ACC_HI: begin
          if (mem.ready)
            state <= DONE;
        end
        DONE: begin
          state  <= IDLE;
          mem.we <= 1'b0;
          WB_Out <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (finish) begin
        WB_Out         <= op_wb;
        WB_Address_Out <= op_wb_addr;
        WB_Data        <= op_write ? op_data_lo : mem.rdata;
        if (!op_write && op_pc) begin
          PC_Out   <= {mem.rdata, lo_word};
          PC_Valid <= 1'b1;
        end
        if (!op_write && op_flags) begin
          Flags_Out   <= mem.rdata[2:0];
          Flags_Valid <= 1'b1;
        end
      end
    end
  end

endmodule
